// File: rtl/mc_control_if.sv
// ============================================================================
// mc_control_if : instruction/handshake/strobe bundle between the multi-cycle
//                 sequencer and the MIPS datapath.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

interface mc_control_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instr;
  logic             zero;
  logic             rt_zero;
  logic             mem_ready;
  logic [4:0]       t;
  logic [10:0]      alu_f;
  logic             ir_we;
  logic             pc_we;
  logic [1:0]       pc_src;
  logic             mem_rd;
  logic             mem_we;
  logic             rf_we;
  logic             reg_dst;
  logic             alu_src_b;
  logic             mem_to_reg;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  instr, zero, rt_zero, mem_ready,
    output t, alu_f, ir_we, pc_we, pc_src, mem_rd, mem_we, rf_we,
           reg_dst, alu_src_b, mem_to_reg, illegal, retired
  );

  modport slave (
    output instr, zero, rt_zero, mem_ready,
    input  t, alu_f, ir_we, pc_we, pc_src, mem_rd, mem_we, rf_we,
           reg_dst, alu_src_b, mem_to_reg, illegal, retired
  );
endinterface

`default_nettype wire

// File: rtl/mc_control.sv
// ============================================================================
// mc_control : multi-cycle MIPS control sequencer (one-hot T1..T5), decodes
//              the instruction register and counts retired instructions.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_control #(
  parameter int CNT_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  mc_control_if.master  bus
);

  typedef enum logic [4:0] {
    T1 = 5'b00001,
    T2 = 5'b00010,
    T3 = 5'b00100,
    T4 = 5'b01000,
    T5 = 5'b10000
  } state_t;

  localparam logic [5:0]  OP_RTYPE = 6'b000000;
  localparam logic [5:0]  OP_J     = 6'b000010;
  localparam logic [5:0]  OP_BEQ   = 6'b000100;
  localparam logic [5:0]  OP_ADDI  = 6'b001000;
  localparam logic [5:0]  OP_LW    = 6'b100011;
  localparam logic [5:0]  OP_SW    = 6'b101011;
  localparam logic [5:0]  FN_MOVZ  = 6'b001010;
  localparam logic [10:0] ALU_ADD  = 11'b00000100000;
  localparam logic [10:0] ALU_SUB  = 11'b00000100010;

  state_t           r_state;
  state_t           w_next;
  logic [10:0]      r_alu_f;
  logic [10:0]      w_alu_f;
  logic [CNT_W-1:0] r_retired;

  logic       w_retire;
  logic       w_ir_we;
  logic       w_pc_we;
  logic [1:0] w_pc_src;
  logic       w_mem_rd;
  logic       w_mem_we;
  logic       w_rf_we;
  logic       w_reg_dst;
  logic       w_alu_src_b;
  logic       w_mem_to_reg;
  logic       w_illegal;

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic       w_is_r;
  logic       w_is_lw;
  logic       w_is_sw;
  logic       w_is_beq;
  logic       w_is_addi;
  logic       w_funct_ok;
  logic       unused_fields;

  assign w_op      = bus.instr[31:26];
  assign w_funct   = bus.instr[5:0];
  assign w_is_r    = (w_op == OP_RTYPE);
  assign w_is_lw   = (w_op == OP_LW);
  assign w_is_sw   = (w_op == OP_SW);
  assign w_is_beq  = (w_op == OP_BEQ);
  assign w_is_addi = (w_op == OP_ADDI);
  // rt/rd select fields are consumed by the datapath, not by the sequencer
  assign unused_fields = ^bus.instr[20:11];

  always_comb begin
    case (w_funct)
      6'b100000, 6'b100010, 6'b100100, 6'b100101,
      6'b100110, 6'b101010, 6'b001010: w_funct_ok = 1'b1;
      6'b000000:                       w_funct_ok = (bus.instr[25:21] == 5'd0);
      default:                         w_funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_next       = r_state;
    w_retire     = 1'b0;
    w_ir_we      = 1'b0;
    w_pc_we      = 1'b0;
    w_pc_src     = 2'b00;
    w_mem_rd     = 1'b0;
    w_mem_we     = 1'b0;
    w_rf_we      = 1'b0;
    w_reg_dst    = 1'b0;
    w_alu_src_b  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_illegal    = 1'b0;
    w_alu_f      = r_alu_f;

    case (r_state)
      T1: begin
        w_mem_rd = 1'b1;
        if (bus.mem_ready) begin
          w_ir_we = 1'b1;
          w_pc_we = 1'b1;
          w_next  = T2;
        end
      end

      T2: begin
        if (w_op == OP_J) begin
          w_pc_we  = 1'b1;
          w_pc_src = 2'b10;
          w_retire = 1'b1;
          w_next   = T1;
        end else if (w_is_r || w_is_lw || w_is_sw || w_is_beq || w_is_addi) begin
          w_next = T3;
        end else begin
          w_illegal = 1'b1;
          w_retire  = 1'b1;
          w_next    = T1;
        end
      end

      T3: begin
        if (w_is_r) begin
          w_alu_f = bus.instr[10:0];
          if (w_funct_ok) begin
            w_next = T5;
          end else begin
            w_illegal = 1'b1;
            w_retire  = 1'b1;
            w_next    = T1;
          end
        end else if (w_is_beq) begin
          w_alu_f  = ALU_SUB;
          w_retire = 1'b1;
          w_next   = T1;
          if (bus.zero) begin
            w_pc_we  = 1'b1;
            w_pc_src = 2'b01;
          end
        end else begin
          w_alu_f     = ALU_ADD;
          w_alu_src_b = 1'b1;
          w_next      = w_is_addi ? T5 : T4;
        end
      end

      T4: begin
        w_mem_rd = w_is_lw;
        w_mem_we = !w_is_lw;
        if (bus.mem_ready) begin
          if (w_is_lw) begin
            w_next = T5;
          end else begin
            w_retire = 1'b1;
            w_next   = T1;
          end
        end
      end

      T5: begin
        w_retire = 1'b1;
        w_next   = T1;
        if (w_is_r) begin
          w_rf_we   = (w_funct == FN_MOVZ) ? bus.rt_zero : 1'b1;
          w_reg_dst = 1'b1;
        end else if (w_is_addi) begin
          w_rf_we = 1'b1;
        end else if (w_is_lw) begin
          w_rf_we      = 1'b1;
          w_mem_to_reg = 1'b1;
        end
      end

      default: begin
        w_next = T1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= T1;
      r_alu_f   <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == T3) begin
        r_alu_f <= w_alu_f;
      end
      if (w_retire) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  // Strobes are forced low while reset is held so no access leaks during abort
  assign bus.t          = r_state;
  assign bus.alu_f      = w_alu_f;
  assign bus.ir_we      = w_ir_we   & ~rst;
  assign bus.pc_we      = w_pc_we   & ~rst;
  assign bus.pc_src     = w_pc_src;
  assign bus.mem_rd     = w_mem_rd  & ~rst;
  assign bus.mem_we     = w_mem_we  & ~rst;
  assign bus.rf_we      = w_rf_we   & ~rst;
  assign bus.reg_dst    = w_reg_dst;
  assign bus.alu_src_b  = w_alu_src_b;
  assign bus.mem_to_reg = w_mem_to_reg;
  assign bus.illegal    = w_illegal & ~rst;
  assign bus.retired    = r_retired;

endmodule

`default_nettype wire

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle control sequencer for the MIPS datapath; sits directly upstream of the ALU.
- Steps each instruction through one-hot timing states T1..T5 and decodes the latched instruction.
- Drives the ALU function code (shamt+funct format, 11 bits) and the T3 strobe.
- Generates every datapath write/read strobe and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- instr  input  32  instruction register contents; stable from T2 onward.
- zero  input  1  ALU result == 0, sampled in T3 for beq.
- rt_zero  input  1  register rt value == 0, sampled for movz write-back.
- mem_ready  input  1  memory access complete this cycle.
- t  output  5  one-hot timing state; t[0]=T1 … t[4]=T5; t[2] drives ALU t3.
- alu_f  output  11  ALU function code.
- ir_we  output  1  load instruction register.
- pc_we  output  1  PC write enable.
- pc_src  output  2  00 = pc+4, 01 = branch target, 10 = jump target.
- mem_rd  output  1  memory read request.
- mem_we  output  1  memory write request.
- rf_we  output  1  register file write enable.
- reg_dst  output  1  1 = rd, 0 = rt.
- alu_src_b  output  1  1 = sign-extended immediate, 0 = rt.
- mem_to_reg  output  1  1 = write-back from memory data.
- illegal  output  1  one-cycle pulse on unsupported opcode/funct.
- retired  output  CNT_W  count of completed instructions.

Behaviour:
- Reset (async, active-high): state = T1, retired = 0.
  - While rst is high, all strobes (ir_we, pc_we, mem_rd, mem_we, rf_we, illegal) = 0, t = 5'b00001, alu_f = 0, pc_src = 00, mux selects = 0.
  - Reset mid-instruction aborts it; no pending write is issued.
- State register updates on the rising edge of clk; all outputs are combinational from state, instr, zero, rt_zero and mem_ready.
- T1 (fetch):
  - mem_rd = 1.
  - When mem_ready = 1: ir_we = 1, pc_we = 1, pc_src = 00, then go to T2.
  - Otherwise hold T1 with ir_we = pc_we = 0.
- T2 (decode), opcode = instr[31:26]:
  - j (000010): pc_we = 1, pc_src = 10, retire, go to T1.
  - R-type (000000), lw (100011), sw (101011), beq (000100), addi (001000): go to T3.
  - Any other opcode: illegal = 1, retire, go to T1.
- T3 (execute):
  - R-type: alu_f = instr[10:0], alu_src_b = 0.
    - Legal funct values: 100000, 100010, 100100, 100101, 100110, 101010, 001010.
    - Also legal: 000000 (sll), but only when instr[25:21] = 0.
    - Otherwise illegal = 1, retire, go to T1.
  - lw/sw/addi: alu_f = 11'b00000100000, alu_src_b = 1.
  - beq: alu_f = 11'b00000100010, alu_src_b = 0.
    - If zero = 1: pc_we = 1, pc_src = 01.
    - Retire, go to T1.
  - Next state: R-type/addi → T5; lw/sw → T4.
- T4 (memory):
  - lw: mem_rd = 1; sw: mem_we = 1. Hold T4 until mem_ready = 1.
  - sw: retire on mem_ready, go to T1.
  - lw: go to T5 on mem_ready.
  - mem_we must not be asserted in any other state.
- T5 (write-back), always one cycle, then retire and go to T1:
  - R-type: rf_we = 1, reg_dst = 1.
    - Exception for movz (funct 001010): rf_we = rt_zero.
  - addi: rf_we = 1, reg_dst = 0.
  - lw: rf_we = 1, reg_dst = 0, mem_to_reg = 1.
- alu_f is held at the last decoded value outside T3 so the ALU input stays stable; it is 0 after reset.
- Retire:
  - retired increments by 1 on the clock edge that leaves an instruction's final state, including illegal-terminated instructions.
  - retired wraps from all-ones to 0.
- Latencies in cycles, with zero memory wait: j = 2, beq = 3, R/addi = 4, sw = 4, lw = 5.
  - Each mem_ready-low cycle in T1 or T4 adds one cycle.
- mem_ready high in any state other than T1/T4 is ignored.

Test Plan:
- Reset, mem_ready = 1, instr = add $3,$1,$2 (0x00221820) → t = 1,2,4,8→skip,16; alu_f = 11'h020 in T3; rf_we = 1 and reg_dst = 1 in T5; retired = 1 after 4 cycles.
- lw (0x8C220004) with mem_ready low 2 cycles in T4 → T4 lasts 3 cycles; mem_rd = 1 throughout; mem_to_reg = 1 and rf_we = 1 in T5; total 7 cycles.
- beq (0x10220003): zero = 1 → pc_we = 1, pc_src = 01 in T3; rerun with zero = 0 → pc_we = 0 in T3; both retire after 3 cycles.
- movz (0x0022180A): rt_zero = 0 → rf_we = 0 in T5; rt_zero = 1 → rf_we = 1; alu_f = 11'h00A in T3.
- Opcode 0x3F (instr 0xFC000000) → illegal pulses in T2; returns to T1; no rf_we/mem_we; retired increments by 1.
- rst asserted mid-T4 of sw → mem_we drops immediately; t = 00001; retired = 0; a clean fetch follows after release.
